// File: rtl/vit_pkg.sv
// Viterbi decoder controller: shared defaults and FSM state type.
package vit_pkg;

  localparam int VIT_FRAME_LEN = 1024;
  localparam int VIT_AW        = 10;

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    TRACEBACK
  } state_e;

endpackage

// File: rtl/vit_addr_cnt.sv
// Loadable up/down address counter with enable and terminal-count flag.
module vit_addr_cnt
  import vit_pkg::*;
#(
  parameter int AW = VIT_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [AW-1:0] load_val_i,
  input  logic          en_i,
  input  logic          up_i,
  input  logic [AW-1:0] tc_val_i,
  output logic [AW-1:0] cnt_o,
  output logic          tc_o
);

  logic [AW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = up_i ? cnt_q + 1'b1 : cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == tc_val_i);

endmodule

// File: rtl/vit_ctrl.sv
// Viterbi decoder frame controller: symbol intake, ACS/survivor write
// sequencing, then reverse-order traceback with one-cycle read latency.
module vit_ctrl
  import vit_pkg::*;
#(
  parameter int FRAME_LEN = VIT_FRAME_LEN,
  parameter int AW        = VIT_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic          bmc_load,
  output logic          acs_clr,
  output logic          acs_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [AW-1:0] mem_raddr,
  output logic          tb_en,
  output logic          dec_valid,
  output logic          dec_last,
  output logic          busy,
  output logic          done
);

  localparam logic [AW:0]   FL_C   = (AW+1)'(FRAME_LEN);
  localparam logic [AW-1:0] LAST_A = AW'(FRAME_LEN - 1);

  state_e      state_q, state_d;
  logic [AW:0] sym_cnt_q, sym_cnt_d;
  logic        acc_q, acc_d;
  logic        dv_q, dv_d;
  logic        dl_q, dl_d;

  logic        w_load, w_en, w_tc;
  logic        r_load, r_en, r_tc;

  vit_addr_cnt #(.AW(AW)) u_wcnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (w_load),
    .load_val_i ('0),
    .en_i       (w_en),
    .up_i       (1'b1),
    .tc_val_i   (LAST_A),
    .cnt_o      (mem_waddr),
    .tc_o       (w_tc)
  );

  vit_addr_cnt #(.AW(AW)) u_rcnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (r_load),
    .load_val_i (LAST_A),
    .en_i       (r_en),
    .up_i       (1'b0),
    .tc_val_i   ('0),
    .cnt_o      (mem_raddr),
    .tc_o       (r_tc)
  );

  always_comb begin
    state_d   = state_q;
    sym_cnt_d = sym_cnt_q;
    acs_clr   = 1'b0;
    w_load    = 1'b0;
    w_en      = 1'b0;
    r_load    = 1'b0;
    r_en      = 1'b0;
    tb_en     = 1'b0;
    rx_ready  = (state_q == DECODE) && (sym_cnt_q < FL_C);
    bmc_load  = rx_ready && rx_valid;

    unique case (state_q)
      IDLE: begin
        if (start && !abort && !rst) begin
          state_d   = DECODE;
          acs_clr   = 1'b1;
          sym_cnt_d = '0;
          w_load    = 1'b1;
        end
      end
      DECODE: begin
        if (bmc_load) begin
          sym_cnt_d = sym_cnt_q + 1'b1;
        end
        // Last survivor write hands over to traceback at the next edge
        if (acc_q) begin
          if (w_tc) begin
            state_d = TRACEBACK;
            r_load  = 1'b1;
          end else begin
            w_en = 1'b1;
          end
        end
      end
      TRACEBACK: begin
        if (dl_q) begin
          state_d = IDLE;
        end else begin
          tb_en = 1'b1;
          r_en  = !r_tc;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d = IDLE;
      r_load  = 1'b0;
      w_en    = 1'b0;
    end

    acc_d = bmc_load && !abort;
    dv_d  = tb_en && !abort;
    dl_d  = tb_en && r_tc && !abort;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sym_cnt_q <= '0;
      acc_q     <= 1'b0;
      dv_q      <= 1'b0;
      dl_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      sym_cnt_q <= sym_cnt_d;
      acc_q     <= acc_d;
      dv_q      <= dv_d;
      dl_q      <= dl_d;
    end
  end

  assign acs_en    = acc_q;
  assign mem_we    = acc_q;
  assign dec_valid = dv_q;
  assign dec_last  = dl_q;
  assign done      = dl_q;
  assign busy      = (state_q != IDLE);

endmodule
